// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared state encoding and fetch-stage constants
package fetch_sequencer_pkg;
  localparam logic [1:0] FS_BOOT = 2'd0;
  localparam logic [1:0] FS_RUN = 2'd1;
  localparam logic [1:0] FS_HALTED = 2'd2;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {
    ST_BOOT = FS_BOOT,
    ST_RUN = FS_RUN,
    ST_HALTED = FS_HALTED
  } fs_state_t;
endpackage

// File: rtl/next_pc_select.sv
// next_pc_select: priority mux for next PC, IF/ID flush and alignment fault
module next_pc_select import fetch_sequencer_pkg::*; #(
  parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT,
  parameter bit DELAY_SLOT = 1'b1
) (
  input  fs_state_t   state,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] target,
  input  logic        trap_req,
  input  logic        halt_req,
  output logic [31:0] next_pc,
  output logic [31:0] epc_next,
  output logic        epc_load,
  output logic        flush,
  output logic        align_fault
);
  logic run, hlt, advance, take_redir;
  always_comb begin
    run = state == ST_RUN;
    hlt = state == ST_HALTED;
    align_fault = run && !trap_req && redirect && (target[1:0] != 2'b00);
    epc_load = ((run || hlt) && trap_req) || align_fault;
    epc_next = trap_req ? pc : target;
    advance = run && !stall && !halt_req && !epc_load;
    take_redir = advance && redirect;
    flush = hlt || epc_load || (take_redir && !DELAY_SLOT);
    next_pc = epc_load ? TRAP_VECTOR : take_redir ? target : advance ? pc + 32'd4 : pc;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC register, BOOT/RUN/HALTED control and IF/ID write/flush
module fetch_sequencer import fetch_sequencer_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT,
  parameter bit DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        id_shouldJumpOrBranch,
  input  logic [31:0] id_jumpOrBranchPc,
  input  logic        trap_req,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic [31:0] epc,
  output logic        align_fault,
  output logic        halted,
  output logic [31:0] fetch_count
);
  fs_state_t state;
  logic [31:0] next_pc, epc_next;
  logic epc_load, flush;
  next_pc_select #(.TRAP_VECTOR(TRAP_VECTOR), .DELAY_SLOT(DELAY_SLOT)) u_sel (
    .state(state),
    .pc(pc),
    .stall(stall),
    .redirect(id_shouldJumpOrBranch),
    .target(id_jumpOrBranchPc),
    .trap_req(trap_req),
    .halt_req(halt_req),
    .next_pc(next_pc),
    .epc_next(epc_next),
    .epc_load(epc_load),
    .flush(flush),
    .align_fault(align_fault)
  );
  // a flush must still load the bubble even while the hazard unit stalls
  always_comb begin
    pc_valid = state == ST_RUN;
    halted = state == ST_HALTED;
    if_id_flush = flush;
    if_id_write = pc_valid && (!stall || flush);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
      pc <= RESET_PC;
      epc <= '0;
      fetch_count <= '0;
    end else begin
      state <= state == ST_BOOT ? ST_RUN
             : state == ST_RUN ? ((halt_req && !stall && !epc_load) ? ST_HALTED : ST_RUN)
             : state == ST_HALTED ? ((trap_req || (resume && !halt_req)) ? ST_RUN : ST_HALTED)
             : ST_BOOT;
      pc <= next_pc;
      if (epc_load) epc <= epc_next;
      fetch_count <= fetch_count + 32'(pc_valid && if_id_write && !if_id_flush);
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed table plus randomized run against a spec-level model
module tb_fetch_sequencer;
  localparam logic [31:0] TV = 32'h0000_0100;
  logic clk = 0, rst_n = 0, stall = 0, jmp = 0, trap_req = 0, halt_req = 0, resume = 0;
  logic [31:0] tgt = 0;
  logic [31:0] d_pc [2], d_epc [2], d_cnt [2];
  logic d_valid [2], d_wr [2], d_fl [2], d_af [2], d_hl [2];
  int checks = 0, errors = 0;
  // index 0 executes the delay slot, index 1 flushes it
  fetch_sequencer #(.DELAY_SLOT(1'b1)) u_ds1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .id_shouldJumpOrBranch(jmp),
    .id_jumpOrBranchPc(tgt), .trap_req(trap_req), .halt_req(halt_req), .resume(resume),
    .pc(d_pc[0]), .pc_valid(d_valid[0]), .if_id_write(d_wr[0]), .if_id_flush(d_fl[0]),
    .epc(d_epc[0]), .align_fault(d_af[0]), .halted(d_hl[0]), .fetch_count(d_cnt[0])
  );
  fetch_sequencer #(.DELAY_SLOT(1'b0)) u_ds0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .id_shouldJumpOrBranch(jmp),
    .id_jumpOrBranchPc(tgt), .trap_req(trap_req), .halt_req(halt_req), .resume(resume),
    .pc(d_pc[1]), .pc_valid(d_valid[1]), .if_id_write(d_wr[1]), .if_id_flush(d_fl[1]),
    .epc(d_epc[1]), .align_fault(d_af[1]), .halted(d_hl[1]), .fetch_count(d_cnt[1])
  );
  always #5 clk = ~clk;
  bit m_boot [2], m_halt [2], n_boot [2], n_halt [2];
  logic [31:0] m_pc [2], m_epc [2], m_cnt [2], n_pc [2], n_epc [2], n_cnt [2];
  bit e_valid [2], e_write [2], e_flush [2], e_align [2];
  typedef struct {
    logic [4:0] in;
    logic [31:0] tg, pc, epc, cnt;
    logic [5:0] fl;
  } vec_t;
  vec_t tbl [21];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model_reset;
    for (int k = 0; k < 2; k++) begin
      m_boot[k] = 1; m_halt[k] = 0; m_pc[k] = 0; m_epc[k] = 0; m_cnt[k] = 0;
    end
  endtask
  task automatic model_eval;
    for (int k = 0; k < 2; k++) begin
      n_boot[k] = 0; n_halt[k] = m_halt[k]; n_pc[k] = m_pc[k]; n_epc[k] = m_epc[k];
      e_valid[k] = 0; e_write[k] = 0; e_flush[k] = 0; e_align[k] = 0;
      if (m_boot[k]) begin
        n_boot[k] = 0;
      end else if (m_halt[k]) begin
        e_flush[k] = 1;
        if (trap_req) begin
          n_pc[k] = TV; n_epc[k] = m_pc[k]; n_halt[k] = 0;
        end else if (resume && !halt_req) n_halt[k] = 0;
      end else begin
        e_valid[k] = 1;
        e_write[k] = !stall;
        if (trap_req) begin
          e_flush[k] = 1; e_write[k] = 1; n_pc[k] = TV; n_epc[k] = m_pc[k];
        end else if (jmp && (tgt % 4) != 0) begin
          e_align[k] = 1; e_flush[k] = 1; e_write[k] = 1; n_pc[k] = TV; n_epc[k] = tgt;
        end else if (stall) begin
          n_pc[k] = m_pc[k];
        end else if (halt_req) begin
          n_halt[k] = 1;
        end else if (jmp) begin
          n_pc[k] = tgt; e_flush[k] = (k == 1);
        end else n_pc[k] = m_pc[k] + 4;
      end
      n_cnt[k] = m_cnt[k] + ((e_valid[k] && e_write[k] && !e_flush[k]) ? 1 : 0);
    end
  endtask
  task automatic model_commit;
    for (int k = 0; k < 2; k++) begin
      m_boot[k] = n_boot[k]; m_halt[k] = n_halt[k];
      m_pc[k] = n_pc[k]; m_epc[k] = n_epc[k]; m_cnt[k] = n_cnt[k];
    end
  endtask
  task automatic check_model;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model_pc[%0d]", k), d_pc[k], m_pc[k]);
      chk($sformatf("model_epc[%0d]", k), d_epc[k], m_epc[k]);
      chk($sformatf("model_cnt[%0d]", k), d_cnt[k], m_cnt[k]);
      chk($sformatf("model_flags[%0d]", k), {d_valid[k], d_wr[k], d_fl[k], d_af[k], d_hl[k]},
          {e_valid[k], e_write[k], e_flush[k], e_align[k], m_halt[k]});
    end
  endtask
  task automatic step;
    @(negedge clk);
    model_eval;
    check_model;
    @(posedge clk);
    #1 model_commit;
  endtask
  task automatic do_reset;
    rst_n = 0;
    {stall, jmp, trap_req, halt_req, resume} = '0;
    tgt = 0;
    model_reset;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask
  initial begin
    // in = {stall, jmp, trap, halt, resume}; fl = {valid, write, flush_ds1, flush_ds0, align, halted}
    tbl[0]  = '{5'b00000, 32'h0,  32'h0,   32'h0,  32'd0,  6'b000000};
    tbl[1]  = '{5'b00000, 32'h0,  32'h0,   32'h0,  32'd0,  6'b110000};
    tbl[2]  = '{5'b00000, 32'h0,  32'h4,   32'h0,  32'd1,  6'b110000};
    tbl[3]  = '{5'b00000, 32'h0,  32'h8,   32'h0,  32'd2,  6'b110000};
    tbl[4]  = '{5'b00000, 32'h0,  32'hC,   32'h0,  32'd3,  6'b110000};
    tbl[5]  = '{5'b01000, 32'h40, 32'h10,  32'h0,  32'd4,  6'b110100};
    tbl[6]  = '{5'b11000, 32'h80, 32'h40,  32'h0,  32'd5,  6'b100000};
    tbl[7]  = '{5'b11000, 32'h80, 32'h40,  32'h0,  32'd5,  6'b100000};
    tbl[8]  = '{5'b01000, 32'h80, 32'h40,  32'h0,  32'd5,  6'b110100};
    tbl[9]  = '{5'b01000, 32'h24, 32'h80,  32'h0,  32'd6,  6'b110100};
    tbl[10] = '{5'b10100, 32'h0,  32'h24,  32'h0,  32'd7,  6'b111100};
    tbl[11] = '{5'b01000, 32'h42, 32'h100, 32'h24, 32'd7,  6'b111110};
    tbl[12] = '{5'b01000, 32'h8,  32'h100, 32'h42, 32'd7,  6'b110100};
    tbl[13] = '{5'b00010, 32'h0,  32'h8,   32'h42, 32'd8,  6'b110000};
    tbl[14] = '{5'b00000, 32'h0,  32'h8,   32'h42, 32'd9,  6'b001101};
    tbl[15] = '{5'b00011, 32'h0,  32'h8,   32'h42, 32'd9,  6'b001101};
    tbl[16] = '{5'b00001, 32'h0,  32'h8,   32'h42, 32'd9,  6'b001101};
    tbl[17] = '{5'b00000, 32'h0,  32'h8,   32'h42, 32'd9,  6'b110000};
    tbl[18] = '{5'b01000, 32'hFFFF_FFFC, 32'hC, 32'h42, 32'd10, 6'b110100};
    tbl[19] = '{5'b00000, 32'h0,  32'hFFFF_FFFC, 32'h42, 32'd11, 6'b110000};
    tbl[20] = '{5'b00000, 32'h0,  32'h0,   32'h42, 32'd12, 6'b110000};
    do_reset;
    for (int i = 0; i < 21; i++) begin
      {stall, jmp, trap_req, halt_req, resume} = tbl[i].in;
      tgt = tbl[i].tg;
      @(negedge clk);
      model_eval;
      check_model;
      chk($sformatf("row%0d_pc", i), d_pc[0], tbl[i].pc);
      chk($sformatf("row%0d_pc_ds0", i), d_pc[1], tbl[i].pc);
      chk($sformatf("row%0d_epc", i), d_epc[0], tbl[i].epc);
      chk($sformatf("row%0d_cnt", i), d_cnt[0], tbl[i].cnt);
      chk($sformatf("row%0d_flags", i), {d_valid[0], d_wr[0], d_fl[0], d_fl[1], d_af[0], d_hl[0]}, tbl[i].fl);
      @(posedge clk);
      #1 model_commit;
    end
    {stall, jmp, trap_req, halt_req, resume} = 5'b00010;
    step;
    halt_req = 0;
    step;
    chk("halted_before_rst", d_hl[0], 1);
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("async_rst_pc[%0d]", k), d_pc[k], 0);
      chk($sformatf("async_rst_epc[%0d]", k), d_epc[k], 0);
      chk($sformatf("async_rst_cnt[%0d]", k), d_cnt[k], 0);
      chk($sformatf("async_rst_flags[%0d]", k), {d_valid[k], d_wr[k], d_fl[k], d_af[k], d_hl[k]}, 0);
    end
    do_reset;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      r = $urandom;
      stall = ($urandom_range(0, 3) == 0);
      jmp = ($urandom_range(0, 4) == 0);
      trap_req = ($urandom_range(0, 24) == 0);
      halt_req = ($urandom_range(0, 19) == 0);
      resume = ($urandom_range(0, 2) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? r : {r[31:2], 2'b00};
      step;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
